// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   HI/LO register pair with an iterative radix-2 shift-add multiplier.
//   It supplies the HI/LO values the ALU reads for madd/msub/mfhi/mflo.
//   It also owns the HI/LO state updated by mult, multu, madd, msub, mthi and mtlo.
//   Busy lets the hazard logic stall HI/LO consumers while a multiply runs.
//
// Ports
//   Clk     rising-edge clock
//   Reset   synchronous active-high reset
//   Start   request strobe, honoured only while idle
//   Op      001 mult, 010 multu, 011 madd, 100 msub, 101 mthi, 110 mtlo,
//           000/111 no operation
//   A, B    rs / rt operands
//   Hi_out  registered HI
//   Lo_out  registered LO
//   Busy    high from the cycle after accept through the commit edge
//   Done    one-cycle pulse in the cycle after HI/LO are committed
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   multiplicand;
  logic [2:0]         op_q;
  logic               sign_q;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;

  logic               is_mul_op;
  logic               is_signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] signed_product;
  logic [2*WIDTH-1:0] acc_result;

  // Operand conditioning at accept time. The multiplier works on magnitudes.
  // The sign is reapplied at ACC. The magnitude of the most negative value
  // wraps to itself, which is the correct unsigned 2^(WIDTH-1).
  always_comb begin
    is_mul_op    = (Op == OP_MULT) || (Op == OP_MULTU) ||
                   (Op == OP_MADD) || (Op == OP_MSUB);
    is_signed_op = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
    abs_a        = (is_signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
    abs_b        = (is_signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;
  end

  // One shift-add step: the upper product half plus the optional multiplicand
  // keeps its carry bit, so the right shift stays lossless.
  always_comb begin
    partial = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) begin
      partial = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, multiplicand};
    end
  end

  // Sign fix and accumulate. This is used only on the ACC edge. madd/msub use
  // the live HI/LO, which cannot change while busy.
  always_comb begin
    signed_product = sign_q ? (~product + 1'b1) : product;
    case (op_q)
      OP_MADD: acc_result = {hi, lo} + signed_product;
      OP_MSUB: acc_result = {hi, lo} - signed_product;
      default: acc_result = signed_product;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: only multiply ops leave IDLE. The moves complete in place.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start && is_mul_op) begin
          state_next = MUL;
        end
      end
      MUL: begin
        if (count == LAST_COUNT) begin
          state_next = ACC;
        end
      end
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO registers. Start is looked at only in IDLE. Requests
  // made while busy are dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count        <= '0;
      product      <= '0;
      multiplicand <= '0;
      op_q         <= '0;
      sign_q       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (Op == OP_MTHI) begin
              hi <= A;
            end else if (Op == OP_MTLO) begin
              lo <= A;
            end else if (is_mul_op) begin
              op_q         <= Op;
              sign_q       <= is_signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
              multiplicand <= abs_a;
              product      <= {{WIDTH{1'b0}}, abs_b};
              count        <= '0;
            end
          end
        end
        MUL: begin
          product <= {partial, product[WIDTH-1:1]};
          count   <= count + 1'b1;
        end
        ACC: begin
          {hi, lo} <= acc_result;
          done     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign Hi_out = hi;
  assign Lo_out = lo;
  assign Busy   = (state != IDLE);
  assign Done   = done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
//   Directed steps and randomized steps for hilo_muldiv_unit. The steps are
//   checked against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi_out;
  logic [31:0] Lo_out;
  logic        Busy;
  logic        Done;

  int compared   = 0;
  int mismatched = 0;

  // The model is the 64-bit {HI,LO} value the design should hold.
  logic [63:0] model_hilo;

  hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Hi_out (Hi_out),
    .Lo_out (Lo_out),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a request for exactly one edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    Op    = 3'b000;
  endtask

  // Compute the full product from the operation's signedness.
  function automatic logic [63:0] refProduct(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (op == 3'b010) begin
      return {32'd0, a} * {32'd0, b};
    end
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Perform mthi or mtlo. The effect is immediate, with no Busy and no Done.
  task automatic doMove(input logic [2:0] op, input logic [31:0] a);
    applyStimulus(op, a, 32'h0);
    if (op == 3'b101) model_hilo[63:32] = a;
    else              model_hilo[31:0]  = a;
    checkOutput("move_hilo", {Hi_out, Lo_out}, model_hilo);
    checkOutput("move_busy", {63'd0, Busy}, 64'd0);
    checkOutput("move_done", {63'd0, Done}, 64'd0);
  endtask

  // Run a multiply-class op and check the Busy window, held HI/LO and Done.
  // At busy cycle inject_at it optionally injects a reset or an mtlo request.
  task automatic runMul(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at,
                        input bit inject_reset);
    logic [63:0] p;
    int          busy_cycles;
    bit          aborted;
    busy_cycles = 0;
    aborted     = 1'b0;
    applyStimulus(op, a, b);
    while (Busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      checkOutput("busy_done_low", {63'd0, Done}, 64'd0);
      checkOutput("busy_hilo_held", {Hi_out, Lo_out}, model_hilo);
      if (busy_cycles == inject_at) begin
        if (inject_reset) begin
          Reset = 1'b1;
          tick();
          Reset   = 1'b0;
          aborted = 1'b1;
          break;
        end else begin
          Start = 1'b1;
          Op    = 3'b110;
          A     = 32'd9;
          tick();
          Start = 1'b0;
          Op    = 3'b000;
        end
      end else begin
        tick();
      end
    end
    if (aborted) begin
      model_hilo = 64'd0;
      checkOutput("abort_busy", {63'd0, Busy}, 64'd0);
      checkOutput("abort_hilo", {Hi_out, Lo_out}, 64'd0);
      for (int i = 0; i < 36; i++) begin
        checkOutput("abort_no_done", {63'd0, Done}, 64'd0);
        tick();
      end
    end else begin
      p = refProduct(op, a, b);
      case (op)
        3'b011:  model_hilo = model_hilo + p;
        3'b100:  model_hilo = model_hilo - p;
        default: model_hilo = p;
      endcase
      checkOutput("busy_cycles", 64'(busy_cycles), 64'd33);
      checkOutput("done_pulse", {63'd0, Done}, 64'd1);
      checkOutput("result_hilo", {Hi_out, Lo_out}, model_hilo);
      tick();
      checkOutput("done_single", {63'd0, Done}, 64'd0);
      checkOutput("idle_busy", {63'd0, Busy}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] corner [0:5];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_0001;
    corner[5] = 32'h0000_0002;

    // Hold reset for two edges while an mthi request is presented. Reset wins.
    Reset = 1'b1;
    Start = 1'b1;
    Op    = 3'b101;
    A     = 32'h1234;
    B     = 32'h0;
    tick();
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    Op    = 3'b000;
    model_hilo = 64'd0;
    checkOutput("reset_hilo", {Hi_out, Lo_out}, 64'd0);
    checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_done", {63'd0, Done}, 64'd0);

    // Signed and unsigned products, including the most negative operands.
    runMul(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    checkOutput("plan2_hilo", {Hi_out, Lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
    runMul(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    checkOutput("plan3a_hilo", {Hi_out, Lo_out}, 64'h0000_0001_FFFF_FFFE);
    runMul(3'b001, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    checkOutput("plan3b_hilo", {Hi_out, Lo_out}, 64'h4000_0000_0000_0000);

    // Moves, then accumulate and subtract.
    doMove(3'b101, 32'd5);
    doMove(3'b110, 32'd7);
    runMul(3'b011, 32'd3, 32'd4, 0, 1'b0);
    checkOutput("plan4a_hilo", {Hi_out, Lo_out}, 64'h0000_0005_0000_0013);
    runMul(3'b100, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    checkOutput("plan4b_hilo", {Hi_out, Lo_out}, 64'hC000_0005_0000_0013);

    // A 64-bit wrap. An mtlo during the MUL phase must be ignored.
    doMove(3'b101, 32'hFFFF_FFFF);
    doMove(3'b110, 32'hFFFF_FFFF);
    runMul(3'b011, 32'd1, 32'd1, 5, 1'b0);
    checkOutput("plan5_hilo", {Hi_out, Lo_out}, 64'd0);

    // Reset partway through a multiply, then a clean multu.
    runMul(3'b001, 32'd7, 32'd9, 10, 1'b1);
    runMul(3'b010, 32'd7, 32'd9, 0, 1'b0);
    checkOutput("plan6_hilo", {Hi_out, Lo_out}, 64'd63);

    // Randomized operations with corner operands mixed in.
    for (int n = 0; n < 24; n++) begin
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rop = 3'($urandom_range(1, 6));
      if (rop == 3'b101 || rop == 3'b110) doMove(rop, ra);
      else                                runMul(rop, ra, rb, 0, 1'b0);
    end

    // Idle no-op codes and Start=0 must leave HI/LO unchanged.
    applyStimulus(3'b000, 32'hDEAD_BEEF, 32'h1);
    checkOutput("nop000_hilo", {Hi_out, Lo_out}, model_hilo);
    applyStimulus(3'b111, 32'hDEAD_BEEF, 32'h1);
    checkOutput("nop111_hilo", {Hi_out, Lo_out}, model_hilo);
    checkOutput("nop_busy", {63'd0, Busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
